data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 110 +++++++++++
 tb/tb_data_mem_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Single-port word memory behind a req/gnt/rvalid handshake with configurable
// grant and response latencies; one transaction outstanding at a time.
module data_mem_responder #(
   parameter int WORD_WIDTH   = 32,
   parameter int DEPTH_WORDS  = 1024,
   parameter int GNT_DELAY    = 0,
   parameter int RVALID_DELAY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    data_req_i,
   input  logic [31:0]             data_addr_i,
   input  logic                    data_we_i,
   input  logic [WORD_WIDTH/8-1:0] data_be_i,
   input  logic [WORD_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [WORD_WIDTH-1:0]   data_rdata_o
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int NB = WORD_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, GNT_WAIT, RESP} state_t;

   state_t                state;
   logic [3:0]            gnt_cnt;
   logic [3:0]            resp_cnt;
   logic                  rvalid_q;
   logic [WORD_WIDTH-1:0] resp_q;
   logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

   logic                  in_range;
   logic [AW-1:0]         word_idx;
   logic [WORD_WIDTH-1:0] load_data;
   logic                  gnt;
   logic                  unused_addr_lsbs;

   assign in_range         = (data_addr_i[31:AW+2] == '0);
   assign word_idx         = data_addr_i[AW+1:2];
   assign unused_addr_lsbs = ^data_addr_i[1:0];
   assign load_data        = (!data_we_i && in_range) ? mem[word_idx] : '0;

   // Grant is combinational so a zero-delay responder accepts in the request cycle.
   always_comb begin
      gnt = 1'b0;
      if (!rst && data_req_i) begin
         case (state)
            IDLE:     gnt = (GNT_DELAY == 0);
            GNT_WAIT: gnt = (gnt_cnt == 4'(GNT_DELAY));
            default:  gnt = 1'b0;
         endcase
      end
   end

   assign data_gnt_o    = gnt;
   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rvalid_q ? resp_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt_cnt  <= '0;
         resp_cnt <= '0;
         rvalid_q <= 1'b0;
         resp_q   <= '0;
      end else begin
         case (state)
            IDLE, GNT_WAIT: begin
               if (gnt) begin
                  state    <= RESP;
                  gnt_cnt  <= '0;
                  resp_cnt <= 4'd1;
                  rvalid_q <= (RVALID_DELAY == 1);
                  resp_q   <= load_data;
               end else if (!data_req_i) begin
                  state   <= IDLE;
                  gnt_cnt <= '0;
               end else if (state == IDLE) begin
                  state   <= GNT_WAIT;
                  gnt_cnt <= 4'd1;
               end else begin
                  gnt_cnt <= gnt_cnt + 4'd1;
               end
            end
            RESP: begin
               if (rvalid_q) begin
                  state    <= IDLE;
                  resp_cnt <= '0;
                  rvalid_q <= 1'b0;
                  resp_q   <= '0;
               end else begin
                  resp_cnt <= resp_cnt + 4'd1;
                  rvalid_q <= ((resp_cnt + 4'd1) == 4'(RVALID_DELAY));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (gnt && data_we_i && in_range) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (data_be_i[b]) mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances cover the grant and
// response latency variants, each driven from one linear stimulus sequence.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst, rst_c;
   logic [31:0] addr, wdata;
   logic        we;
   logic [3:0]  be;

   logic        a_req, b_req, c_req, d_req;
   logic        a_gnt, b_gnt, c_gnt, d_gnt;
   logic        a_rvalid, b_rvalid, c_rvalid, d_rvalid;
   logic [31:0] a_rdata, b_rdata, c_rdata, d_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.GNT_DELAY(0), .RVALID_DELAY(1)) u_a (
      .clk(clk), .rst(rst), .data_req_i(a_req), .data_addr_i(addr), .data_we_i(we),
      .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(a_gnt),
      .data_rvalid_o(a_rvalid), .data_rdata_o(a_rdata));

   data_mem_responder #(.GNT_DELAY(3), .RVALID_DELAY(1)) u_b (
      .clk(clk), .rst(rst), .data_req_i(b_req), .data_addr_i(addr), .data_we_i(we),
      .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(b_gnt),
      .data_rvalid_o(b_rvalid), .data_rdata_o(b_rdata));

   data_mem_responder #(.GNT_DELAY(0), .RVALID_DELAY(4)) u_c (
      .clk(clk), .rst(rst_c), .data_req_i(c_req), .data_addr_i(addr), .data_we_i(we),
      .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(c_gnt),
      .data_rvalid_o(c_rvalid), .data_rdata_o(c_rdata));

   data_mem_responder #(.GNT_DELAY(0), .RVALID_DELAY(2)) u_d (
      .clk(clk), .rst(rst), .data_req_i(d_req), .data_addr_i(addr), .data_we_i(we),
      .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(d_gnt),
      .data_rvalid_o(d_rvalid), .data_rdata_o(d_rdata));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_bus(input logic w, input logic [31:0] ad, input logic [3:0] b,
                          input logic [31:0] d);
      we    = w;
      addr  = ad;
      be    = b;
      wdata = d;
   endtask

   initial begin
      rst = 1'b1; rst_c = 1'b1;
      a_req = 1'b0; b_req = 1'b0; c_req = 1'b0; d_req = 1'b0;
      set_bus(1'b0, 32'h0, 4'h0, 32'h0);
      repeat (2) @(posedge clk);

      // Requests during reset must not be granted
      @(negedge clk); a_req = 1'b1; b_req = 1'b1; c_req = 1'b1; d_req = 1'b1; #1;
      chk("rst_a_gnt", a_gnt, 0);       chk("rst_c_gnt", c_gnt, 0);
      chk("rst_a_rvalid", a_rvalid, 0); chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rvalid", b_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
      @(negedge clk); rst = 1'b0; rst_c = 1'b0;
      a_req = 1'b0; b_req = 1'b0; c_req = 1'b0; d_req = 1'b0; #1;

      // ---- instance A: GNT_DELAY=0, RVALID_DELAY=1 ----
      @(negedge clk); a_req = 1'b1; set_bus(1'b1, 32'h10, 4'hF, 32'hDEADBEEF); #1;
      chk("a_st_gnt", a_gnt, 1); chk("a_st_rv_early", a_rvalid, 0);
      @(negedge clk); a_req = 1'b0; #1;
      chk("a_st_rv", a_rvalid, 1); chk("a_st_rdata", a_rdata, 0);
      @(negedge clk); a_req = 1'b1; set_bus(1'b0, 32'h10, 4'h0, 32'h0); #1;
      chk("a_ld_gnt", a_gnt, 1); chk("a_ld_rv_early", a_rvalid, 0);
      chk("a_ld_rdata_idle", a_rdata, 0);
      @(negedge clk); a_req = 1'b0; #1;
      chk("a_ld_rv", a_rvalid, 1); chk("a_ld_rdata", a_rdata, 32'hDEADBEEF);
      @(negedge clk); #1;
      chk("a_ld_rv_off", a_rvalid, 0); chk("a_ld_rdata_off", a_rdata, 0);

      @(negedge clk); a_req = 1'b1; set_bus(1'b1, 32'h10, 4'b0010, 32'h0000AA00); #1;
      chk("a_pst_gnt", a_gnt, 1);
      @(negedge clk); a_req = 1'b0; #1;
      chk("a_pst_rv", a_rvalid, 1);

      // Request held through the response: no grant until the cycle after rvalid
      @(negedge clk); a_req = 1'b1; set_bus(1'b0, 32'h13, 4'h0, 32'h0); #1;
      chk("a_pld_gnt", a_gnt, 1);
      @(negedge clk); #1;
      chk("a_no_gnt_in_rv", a_gnt, 0); chk("a_pld_rv", a_rvalid, 1);
      chk("a_pld_rdata", a_rdata, 32'hDEADAAEF);
      @(negedge clk); #1;
      chk("a_regnt", a_gnt, 1); chk("a_regnt_rv", a_rvalid, 0);
      @(negedge clk); a_req = 1'b0; #1;
      chk("a_pld2_rv", a_rvalid, 1); chk("a_pld2_rdata", a_rdata, 32'hDEADAAEF);

      @(negedge clk); a_req = 1'b1; set_bus(1'b1, 32'h0, 4'hF, 32'h11111111); #1;
      chk("a_st0_gnt", a_gnt, 1);
      @(negedge clk); a_req = 1'b0; #1;
      chk("a_st0_rv", a_rvalid, 1);

      @(negedge clk); a_req = 1'b1; set_bus(1'b1, 32'h1000, 4'hF, 32'h12345678); #1;
      chk("a_oor_st_gnt", a_gnt, 1);
      @(negedge clk); a_req = 1'b0; #1;
      chk("a_oor_st_rv", a_rvalid, 1); chk("a_oor_st_rdata", a_rdata, 0);
      @(negedge clk); a_req = 1'b1; set_bus(1'b0, 32'h1000, 4'hF, 32'h0); #1;
      chk("a_oor_ld_gnt", a_gnt, 1);
      @(negedge clk); a_req = 1'b0; #1;
      chk("a_oor_ld_rv", a_rvalid, 1); chk("a_oor_ld_rdata", a_rdata, 0);
      @(negedge clk); a_req = 1'b1; set_bus(1'b0, 32'h0, 4'h0, 32'h0); #1;
      chk("a_ld0_gnt", a_gnt, 1);
      @(negedge clk); a_req = 1'b0; #1;
      chk("a_ld0_rv", a_rvalid, 1); chk("a_ld0_no_alias", a_rdata, 32'h11111111);

      // ---- instance B: GNT_DELAY=3 ----
      @(negedge clk); b_req = 1'b1; set_bus(1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1; chk("b_st_gnt", b_gnt, (i == 3));
      end
      @(negedge clk); b_req = 1'b0; #1;
      chk("b_st_rv", b_rvalid, 1); chk("b_st_gnt_off", b_gnt, 0);

      @(negedge clk); b_req = 1'b1; set_bus(1'b1, 32'h20, 4'hF, 32'hBADBAD00); #1;
      chk("b_abort_gnt0", b_gnt, 0);
      @(negedge clk); #1;
      chk("b_abort_gnt1", b_gnt, 0);
      @(negedge clk); b_req = 1'b0; #1;
      chk("b_abort_gnt2", b_gnt, 0); chk("b_abort_rv2", b_rvalid, 0);
      @(negedge clk); #1;
      chk("b_abort_rv3", b_rvalid, 0);

      @(negedge clk); b_req = 1'b1; set_bus(1'b0, 32'h20, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1; chk("b_ld_gnt", b_gnt, (i == 3));
      end
      @(negedge clk); b_req = 1'b0; #1;
      chk("b_ld_rv", b_rvalid, 1); chk("b_ld_rdata", b_rdata, 32'hCAFEF00D);

      // ---- instance C: RVALID_DELAY=4, reset two cycles after grant ----
      @(negedge clk); c_req = 1'b1; set_bus(1'b1, 32'h30, 4'hF, 32'hA5A5A5A5); #1;
      chk("c_st_gnt", c_gnt, 1);
      @(negedge clk); c_req = 1'b0; #1;
      chk("c_rv_g1", c_rvalid, 0);
      @(negedge clk); rst_c = 1'b1; c_req = 1'b1; set_bus(1'b0, 32'h30, 4'h0, 32'h0); #1;
      chk("c_no_gnt_in_rst", c_gnt, 0); chk("c_rv_g2", c_rvalid, 0);
      @(negedge clk); rst_c = 1'b0; c_req = 1'b0; #1;
      chk("c_rv_g3", c_rvalid, 0);
      for (int i = 4; i < 7; i++) begin
         @(negedge clk); #1; chk("c_rv_dropped", c_rvalid, 0);
      end
      @(negedge clk); c_req = 1'b1; #1;
      chk("c_ld_gnt", c_gnt, 1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk); c_req = 1'b0; #1;
         chk("c_ld_rv", c_rvalid, (i == 4));
         chk("c_ld_rdata", c_rdata, (i == 4) ? 32'hA5A5A5A5 : 32'h0);
      end

      // ---- instance D: continuous request, RVALID_DELAY=2 ----
      @(negedge clk); d_req = 1'b1; set_bus(1'b0, 32'h10, 4'h0, 32'h0);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         chk("d_gnt", d_gnt, (i % 3 == 0));
         chk("d_rv", d_rvalid, (i % 3 == 2));
      end
      @(negedge clk); d_req = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
